// File: rtl/morse_msg_sequencer.sv
// morse_msg_sequencer: queues letter codes and feeds Morse unit patterns to the transmitter with letter/word gaps
module morse_msg_sequencer #(
    parameter int DEPTH      = 8,
    parameter int LETTER_GAP = 3,
    parameter int WORD_GAP   = 4
) (
    input  logic        half_sec,
    input  logic        reset,
    input  logic [4:0]  letter_in,
    input  logic        letter_valid,
    input  logic        start,
    input  logic        tx_ready,
    output logic        tx_start,
    output logic [12:0] tx_pattern,
    output logic [3:0]  tx_len,
    output logic        fifo_full,
    output logic        fifo_empty,
    output logic        busy,
    output logic        letter_done,
    output logic        bad_code,
    output logic        tx_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [4:0] SPACE = 5'd26;

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_ACK, SEND, GAP} state_t;

    state_t        state;
    logic [4:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [3:0]    gap_cnt;
    logic [1:0]    ack_cnt;
    logic          pop, push;
    logic [4:0]    head;
    logic [16:0]   rom_out;

    // {element count, elements first-at-bit-3}, 1 = dash
    function automatic logic [6:0] morse(input logic [4:0] c);
        case (c)
            5'd0:  return 7'b010_0100;
            5'd1:  return 7'b100_1000;
            5'd2:  return 7'b100_1010;
            5'd3:  return 7'b011_1000;
            5'd4:  return 7'b001_0000;
            5'd5:  return 7'b100_0010;
            5'd6:  return 7'b011_1100;
            5'd7:  return 7'b100_0000;
            5'd8:  return 7'b010_0000;
            5'd9:  return 7'b100_0111;
            5'd10: return 7'b011_1010;
            5'd11: return 7'b100_0100;
            5'd12: return 7'b010_1100;
            5'd13: return 7'b010_1000;
            5'd14: return 7'b011_1110;
            5'd15: return 7'b100_0110;
            5'd16: return 7'b100_1101;
            5'd17: return 7'b011_0100;
            5'd18: return 7'b011_0000;
            5'd19: return 7'b001_1000;
            5'd20: return 7'b011_0010;
            5'd21: return 7'b100_0001;
            5'd22: return 7'b011_0110;
            5'd23: return 7'b100_1001;
            5'd24: return 7'b100_1011;
            5'd25: return 7'b100_1100;
            default: return 7'b000_0000;
        endcase
    endfunction

    // each element is emitted with a leading 0 separator; the first one falls off when left-justifying
    function automatic logic [16:0] encode(input logic [6:0] m);
        logic [13:0] p;
        logic [4:0]  l;
        logic [3:0]  e;
        p = '0;
        l = '0;
        e = m[3:0];
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < m[6:4]) begin
                p = e[3] ? {p[9:0], 4'b0111} : {p[11:0], 2'b01};
                l = l + (e[3] ? 5'd4 : 5'd2);
            end
            e = {e[2:0], 1'b0};
        end
        p = p << (5'd14 - l);
        return {4'(l - 5'd1), p[12:0]};
    endfunction

    assign head       = mem[rd_ptr];
    assign rom_out    = encode(morse(head));
    assign fifo_empty = count == '0;
    assign fifo_full  = count == (AW+1)'(DEPTH);
    assign busy       = state != IDLE;
    assign tx_start   = state == LOAD && tx_ready;
    assign pop        = state == IDLE && start && !fifo_empty;
    assign push       = letter_valid && letter_in <= SPACE && (!fifo_full || pop);

    always_ff @(posedge half_sec)
        if (push) mem[wr_ptr] <= letter_in;

    always_ff @(posedge half_sec or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            bad_code <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(push);
            rd_ptr   <= rd_ptr + AW'(pop);
            count    <= count + (AW+1)'(push) - (AW+1)'(pop);
            bad_code <= bad_code || (letter_valid && letter_in > SPACE);
        end
    end

    always_ff @(posedge half_sec or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            tx_pattern  <= '0;
            tx_len      <= '0;
            gap_cnt     <= '0;
            ack_cnt     <= '0;
            letter_done <= 1'b0;
            tx_err      <= 1'b0;
        end else begin
            letter_done <= 1'b0;
            case (state)
                IDLE: if (pop) begin
                    if (head == SPACE) begin
                        state   <= GAP;
                        gap_cnt <= 4'(WORD_GAP);
                    end else begin
                        state                <= LOAD;
                        {tx_len, tx_pattern} <= rom_out;
                    end
                end
                LOAD: if (tx_ready) begin
                    state   <= WAIT_ACK;
                    ack_cnt <= '0;
                end
                WAIT_ACK: if (!tx_ready) state <= SEND;
                else if (ack_cnt == 2'd2) begin
                    state   <= GAP;
                    gap_cnt <= 4'(LETTER_GAP);
                    tx_err  <= 1'b1;
                end else ack_cnt <= ack_cnt + 2'd1;
                SEND: if (tx_ready) begin
                    state       <= GAP;
                    gap_cnt     <= 4'(LETTER_GAP);
                    letter_done <= 1'b1;
                end
                GAP: if (gap_cnt == 4'd1) state <= IDLE;
                else gap_cnt <= gap_cnt - 4'd1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_morse_msg_sequencer.sv
// tb_morse_msg_sequencer: vector table, corner sequences and randomized run against a message-level model
module tb_morse_msg_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  letter_in = '0;
    logic        letter_valid = 1'b0, start = 1'b0, force_ready = 1'b0;
    logic        tx_ready, tx_start, fifo_full, fifo_empty, busy, letter_done, bad_code, tx_err;
    logic [12:0] tx_pattern;
    logic [3:0]  tx_len;
    int          checks = 0, errors = 0, tcnt = 0;

    string morse_tab [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                              "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                              "..-", "...-", ".--", "-..-", "-.--", "--.."};

    typedef struct {
        logic [4:0]  code;
        logic [12:0] pat;
        logic [3:0]  len;
    } vec_t;
    vec_t vecs [8];

    always #5 clk = ~clk;

    morse_msg_sequencer dut (
        .half_sec(clk), .reset(reset), .letter_in(letter_in), .letter_valid(letter_valid),
        .start(start), .tx_ready(tx_ready), .tx_start(tx_start), .tx_pattern(tx_pattern),
        .tx_len(tx_len), .fifo_full(fifo_full), .fifo_empty(fifo_empty), .busy(busy),
        .letter_done(letter_done), .bad_code(bad_code), .tx_err(tx_err)
    );

    // transmitter stand-in: ready drops for tx_len cycles after each strobe
    always @(posedge clk or posedge reset)
        if (reset) tcnt <= 0;
        else if (tx_start) tcnt <= int'(tx_len);
        else if (tcnt > 0) tcnt <= tcnt - 1;
    assign tx_ready = force_ready || tcnt == 0;

    function automatic logic [16:0] ref_code(input int c);
        string s;
        int n;
        logic [12:0] p;
        s = morse_tab[c];
        n = 0;
        p = '0;
        for (int i = 0; i < s.len(); i++) begin
            if (i > 0) n++;
            repeat (s[i] == "-" ? 3 : 1) begin
                p = p | (13'h1000 >> n);
                n++;
            end
        end
        return {4'(n), p};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        letter_valid = 1'b0;
        start = 1'b0;
        force_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push(input logic [4:0] c);
        letter_in = c;
        letter_valid = 1'b1;
        @(negedge clk);
        letter_valid = 1'b0;
    endtask

    task automatic observe_letter(input string tag, input logic [12:0] pat, input logic [3:0] len,
                                  input int exp_done, input int exp_busy);
        int starts = 0, dones = 0, after = 0, bcyc = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_start) break;
        end
        check({tag, "_strobe"}, tx_start, 1);
        check({tag, "_pat"}, tx_pattern, pat);
        check({tag, "_len"}, tx_len, len);
        while (busy && bcyc < 60) begin
            starts += int'(tx_start);
            dones += int'(letter_done);
            if (dones > 0) after++;
            bcyc++;
            @(negedge clk);
        end
        check({tag, "_nstrobe"}, starts, 1);
        check({tag, "_ndone"}, dones, exp_done);
        check({tag, "_busycyc"}, bcyc, exp_busy);
        if (exp_done > 0) check({tag, "_gapcyc"}, after, 3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int idx[$];
        logic [12:0] pats[$];
        logic [3:0] lens[$];
        int bsum, cnt;
        int q[$];
        int busy_left, cur_period, c;
        bit cur_letter, bad_m, pop_m, exp_start;
        logic [16:0] cur_exp, r;

        vecs[0] = '{5'd4,  13'b1000000000000, 4'd1};
        vecs[1] = '{5'd19, 13'b1110000000000, 4'd3};
        vecs[2] = '{5'd0,  13'b1011100000000, 4'd5};
        vecs[3] = '{5'd24, 13'b1110101110111, 4'd13};
        vecs[4] = '{5'd18, 13'b1010100000000, 4'd5};
        vecs[5] = '{5'd14, 13'b1110111011100, 4'd11};
        vecs[6] = '{5'd16, 13'b1110111010111, 4'd13};
        vecs[7] = '{5'd25, 13'b1110111010100, 4'd11};

        @(negedge clk);
        check("rst_tx_start", tx_start, 0);
        check("rst_pattern", tx_pattern, 0);
        check("rst_len", tx_len, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_busy", busy, 0);
        check("rst_done", letter_done, 0);
        check("rst_bad", bad_code, 0);
        check("rst_err", tx_err, 0);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            start = 1'b1;
            push(vecs[i].code);
            observe_letter($sformatf("vec%0d", i), vecs[i].pat, vecs[i].len, 1, 5 + int'(vecs[i].len));
        end

        // A, word space, T back to back
        do_reset();
        push(5'd0);
        push(5'd26);
        push(5'd19);
        start = 1'b1;
        bsum = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tx_start) begin
                idx.push_back(k);
                pats.push_back(tx_pattern);
                lens.push_back(tx_len);
            end
            bsum += int'(busy);
        end
        check("ats_nstrobe", idx.size(), 2);
        check("ats_busysum", bsum, 22);
        if (idx.size() == 2) begin
            check("ats_spacing", idx[1] - idx[0], 16);
            check("ats_a_len", lens[0], 5);
            check("ats_t_pat", pats[1], 13'b1110000000000);
            check("ats_t_len", lens[1], 3);
        end

        // overfill with start low, then drain
        do_reset();
        for (int i = 0; i < 8; i++) push(5'(i));
        check("fill_full8", fifo_full, 1);
        push(5'd9);
        check("fill_full9", fifo_full, 1);
        check("fill_idle", busy, 0);
        start = 1'b1;
        cnt = 0;
        for (int k = 0; k < 250; k++) begin
            @(negedge clk);
            if (tx_start) begin
                r = ref_code(cnt);
                if (cnt < 9) check($sformatf("fill_pat%0d", cnt), tx_pattern, r[12:0]);
                cnt++;
            end
        end
        check("fill_count", cnt, 8);
        check("fill_empty", fifo_empty, 1);
        check("fill_busy_end", busy, 0);

        // illegal code
        do_reset();
        start = 1'b1;
        push(5'd29);
        check("bad_flag", bad_code, 1);
        check("bad_empty", fifo_empty, 1);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            cnt += int'(tx_start) + int'(busy);
        end
        check("bad_no_tx", cnt, 0);

        // transmitter never acknowledges
        do_reset();
        force_ready = 1'b1;
        start = 1'b1;
        push(5'd19);
        observe_letter("stuck", 13'b1110000000000, 4'd3, 0, 7);
        check("stuck_err", tx_err, 1);
        check("stuck_idle", busy, 0);
        force_ready = 1'b0;

        // reset while Y is in SEND with letters queued
        do_reset();
        start = 1'b1;
        push(5'd24);
        push(5'd0);
        push(5'd1);
        push(5'd2);
        @(negedge clk);
        @(negedge clk);
        check("midrst_busy", busy, 1);
        check("midrst_queued", fifo_empty, 0);
        #2 reset = 1'b1;
        #1;
        check("midrst_tx_start", tx_start, 0);
        check("midrst_busy0", busy, 0);
        check("midrst_pattern", tx_pattern, 0);
        check("midrst_len", tx_len, 0);
        check("midrst_empty", fifo_empty, 1);
        check("midrst_full", fifo_full, 0);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            cnt += int'(tx_start);
        end
        check("midrst_no_tx", cnt, 0);

        // randomized traffic against the message-level model
        do_reset();
        q.delete();
        busy_left = 0;
        cur_period = 0;
        cur_letter = 1'b0;
        cur_exp = '0;
        bad_m = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            check("rnd_empty", fifo_empty, q.size() == 0);
            check("rnd_full", fifo_full, q.size() == 8);
            check("rnd_busy", busy, busy_left > 0);
            check("rnd_bad", bad_code, bad_m);
            exp_start = cur_letter && busy_left == cur_period && busy_left > 0;
            check("rnd_strobe", tx_start, exp_start);
            if (exp_start) begin
                check("rnd_pat", tx_pattern, cur_exp[12:0]);
                check("rnd_len", tx_len, cur_exp[16:13]);
            end
            check("rnd_done", letter_done, cur_letter && busy_left == 3);
            letter_valid = $urandom_range(0, 3) == 0;
            letter_in = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(27, 31)) : 5'($urandom_range(0, 26));
            start = $urandom_range(0, 7) != 0;
            pop_m = busy_left == 0 && start && q.size() > 0;
            if (busy_left > 0) busy_left--;
            if (pop_m) begin
                c = q.pop_front();
                cur_letter = c != 26;
                if (cur_letter) begin
                    cur_exp = ref_code(c);
                    cur_period = 5 + int'(cur_exp[16:13]);
                end else cur_period = 4;
                busy_left = cur_period;
            end
            if (letter_valid) begin
                if (letter_in > 5'd26) bad_m = 1'b1;
                else if (q.size() < 8) q.push_back(int'(letter_in));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
